// File: rtl/m68k_irq_ctrl_if.sv
// CPU bus and register-file bus between the 68000 side and the interrupt controller.
interface m68k_irq_ctrl_if;
  logic [2:0]  cpu_fc;
  logic        cpu_as_n;
  logic [2:0]  cpu_addr;
  logic [2:0]  ipl_n;
  logic        vpa_n;
  logic        reg_cs;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [15:0] reg_din;
  logic [15:0] reg_dout;

  modport master (
    output cpu_fc, cpu_as_n, cpu_addr, reg_cs, reg_we, reg_addr, reg_din,
    input  ipl_n, vpa_n, reg_dout
  );

  modport slave (
    input  cpu_fc, cpu_as_n, cpu_addr, reg_cs, reg_we, reg_addr, reg_din,
    output ipl_n, vpa_n, reg_dout
  );
endinterface

// File: rtl/m68k_irq_ctrl.sv
// 68000 interrupt controller: per-source level and edge/level mode, autovector IACK clear,
// mask/pending/force register file and freeze-aware source sampling.
module m68k_irq_ctrl #(
  parameter int unsigned          NUM_SRC   = 4,
  parameter logic [NUM_SRC*3-1:0] SRC_LEVEL = {3'd7, 3'd6, 3'd5, 3'd4},
  parameter logic [NUM_SRC-1:0]   EDGE_MODE = 4'b1111,
  parameter logic [NUM_SRC-1:0]   EDGE_RISE = 4'b0111,
  parameter logic [NUM_SRC-1:0]   RESET_EN  = 4'b1111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               freeze,
  input  logic [NUM_SRC-1:0] src,
  m68k_irq_ctrl_if.slave     bus,
  output logic [NUM_SRC-1:0] pending
);

  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] en_q;
  logic [NUM_SRC-1:0] src_prev_q;
  logic               iack_prev_q;
  logic [2:0]         ipl_q, ipl_d;
  logic [15:0]        dout_q, rd_data;

  logic               iack, iack_start;
  logic [NUM_SRC-1:0] eff_pend, edge_set, iack_clr, w1c_bits, force_bits;
  logic               reg_wr;

  assign iack       = (bus.cpu_fc == 3'b111) && !bus.cpu_as_n;
  assign iack_start = iack && !iack_prev_q;
  assign bus.vpa_n  = ~iack;
  assign bus.ipl_n  = ipl_q;
  assign bus.reg_dout = dout_q;
  assign pending    = pend_q;

  // Level sources bypass the latch and are seen live.
  assign eff_pend = (pend_q & EDGE_MODE) | (src & ~EDGE_MODE);

  assign reg_wr     = bus.reg_cs && bus.reg_we;
  assign w1c_bits   = (reg_wr && bus.reg_addr == 2'd1) ? bus.reg_din[NUM_SRC-1:0] : '0;
  assign force_bits = (reg_wr && bus.reg_addr == 2'd3) ? bus.reg_din[NUM_SRC-1:0] : '0;

  // Source edges; suppressed while frozen, src_prev holds so a spanning edge shows up later.
  always_comb begin
    edge_set = '0;
    if (!freeze) begin
      edge_set = ((src & ~src_prev_q & EDGE_RISE) | (~src & src_prev_q & ~EDGE_RISE))
                 & EDGE_MODE;
    end
  end

  // Pick the lowest-index latched edge source at the acknowledged level.
  always_comb begin
    logic found;
    iack_clr = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && EDGE_MODE[i] && pend_q[i] && (SRC_LEVEL[3*i +: 3] == bus.cpu_addr)) begin
        iack_clr[i] = 1'b1;
        found       = 1'b1;
      end
    end
    if (!iack_start) iack_clr = '0;
  end

  // Sets are applied after clears so a same-cycle new edge is never lost.
  always_comb begin
    pend_d = ((pend_q & ~(iack_clr | w1c_bits)) | edge_set | force_bits) & EDGE_MODE;
  end

  // Highest level among enabled, effectively pending sources.
  always_comb begin
    logic [2:0] max_lvl;
    max_lvl = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (eff_pend[i] && en_q[i] && (SRC_LEVEL[3*i +: 3] > max_lvl)) begin
        max_lvl = SRC_LEVEL[3*i +: 3];
      end
    end
    ipl_d = ~max_lvl;
  end

  // Register-file read mux, upper bits zero.
  always_comb begin
    rd_data = '0;
    case (bus.reg_addr)
      2'd0:    rd_data[NUM_SRC-1:0] = en_q;
      2'd1:    rd_data[NUM_SRC-1:0] = eff_pend;
      2'd2:    rd_data[NUM_SRC-1:0] = src;
      default: rd_data[NUM_SRC-1:0] = pend_q;
    endcase
  end

  // State update; reset samples src and IACK so neither produces a spurious event on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      en_q        <= RESET_EN;
      src_prev_q  <= src;
      iack_prev_q <= iack;
      ipl_q       <= 3'b111;
      dout_q      <= '0;
    end else begin
      pend_q      <= pend_d;
      iack_prev_q <= iack;
      ipl_q       <= ipl_d;
      if (!freeze) src_prev_q <= src;
      if (reg_wr && bus.reg_addr == 2'd0) en_q <= bus.reg_din[NUM_SRC-1:0];
      if (bus.reg_cs && !bus.reg_we) dout_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_m68k_irq_ctrl.sv
// Directed bench for m68k_irq_ctrl with default parameters.
module tb_m68k_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       freeze;
  logic [3:0] src;
  logic [3:0] pending;

  m68k_irq_ctrl_if bus ();

  m68k_irq_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .freeze  (freeze),
    .src     (src),
    .bus     (bus),
    .pending (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  src;
    logic [2:0]  fc;
    logic        as_n;
    logic [2:0]  addr;
    logic        cs;
    logic        we;
    logic [1:0]  ra;
    logic [15:0] din;
    logic [3:0]  e_pend;
    logic [2:0]  e_ipl;
    logic        e_vpa;
    logic [15:0] e_dout;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  task automatic v(input logic [3:0] s, input logic [2:0] fc, input logic as_n,
                   input logic [2:0] a, input logic cs, input logic we, input logic [1:0] ra,
                   input logic [15:0] din, input logic [3:0] ep, input logic [2:0] ei,
                   input logic evpa, input logic [15:0] ed);
    vec_t t;
    t.src = s; t.fc = fc; t.as_n = as_n; t.addr = a; t.cs = cs; t.we = we; t.ra = ra;
    t.din = din; t.e_pend = ep; t.e_ipl = ei; t.e_vpa = evpa; t.e_dout = ed;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.cpu_fc = 3'd0; bus.cpu_as_n = 1'b1; bus.cpu_addr = 3'd0;
    bus.reg_cs = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = 2'd0; bus.reg_din = 16'h0;
  endtask

  initial begin
    // Inputs, then state right after the clock edge that consumed them.
    //  src      fc  as  addr cs we ra din     pend     ipl     vpa  dout
    v(4'b1001, 0, 1, 0, 0, 0, 0, 16'h0, 4'b0001, 3'b111, 1, 16'h0);  // src0 rise
    v(4'b1000, 0, 1, 0, 0, 0, 0, 16'h0, 4'b0001, 3'b011, 1, 16'h0);
    v(4'b1100, 0, 1, 0, 0, 0, 0, 16'h0, 4'b0101, 3'b011, 1, 16'h0);  // src2 rise
    v(4'b1000, 0, 1, 0, 0, 0, 0, 16'h0, 4'b0101, 3'b001, 1, 16'h0);
    v(4'b1000, 7, 0, 6, 0, 0, 0, 16'h0, 4'b0001, 3'b001, 0, 16'h0);  // IACK lvl 6
    v(4'b1000, 7, 0, 4, 0, 0, 0, 16'h0, 4'b0001, 3'b011, 0, 16'h0);  // held: no 2nd clear
    v(4'b1000, 0, 1, 0, 0, 0, 0, 16'h0, 4'b0001, 3'b011, 1, 16'h0);
    v(4'b1000, 7, 0, 4, 0, 0, 0, 16'h0, 4'b0000, 3'b011, 0, 16'h0);  // IACK lvl 4
    v(4'b1000, 0, 1, 0, 0, 0, 0, 16'h0, 4'b0000, 3'b111, 1, 16'h0);
    v(4'b1010, 0, 1, 0, 0, 0, 0, 16'h0, 4'b0010, 3'b111, 1, 16'h0);  // src1 rise
    v(4'b1000, 0, 1, 0, 0, 0, 0, 16'h0, 4'b0010, 3'b010, 1, 16'h0);
    v(4'b1010, 7, 0, 5, 0, 0, 0, 16'h0, 4'b0010, 3'b010, 0, 16'h0);  // edge beats IACK clear
    v(4'b1000, 0, 1, 0, 0, 0, 0, 16'h0, 4'b0010, 3'b010, 1, 16'h0);
    v(4'b1000, 0, 1, 0, 1, 0, 1, 16'h0, 4'b0010, 3'b010, 1, 16'h2);  // read pending
    v(4'b1000, 0, 1, 0, 1, 1, 0, 16'h0, 4'b0010, 3'b010, 1, 16'h2);  // enable = 0
    v(4'b1000, 0, 1, 0, 0, 0, 0, 16'h0, 4'b0010, 3'b111, 1, 16'h2);
    v(4'b1000, 0, 1, 0, 1, 0, 0, 16'h0, 4'b0010, 3'b111, 1, 16'h0);  // read enable
    v(4'b1000, 0, 1, 0, 1, 0, 1, 16'h0, 4'b0010, 3'b111, 1, 16'h2);  // read pending
    v(4'b1000, 0, 1, 0, 1, 1, 3, 16'h5, 4'b0111, 3'b111, 1, 16'h2);  // force
    v(4'b1000, 0, 1, 0, 1, 0, 2, 16'h0, 4'b0111, 3'b111, 1, 16'h8);  // read raw src
    v(4'b1000, 0, 1, 0, 1, 1, 1, 16'hF, 4'b0000, 3'b111, 1, 16'h8);  // W1C all
    v(4'b1000, 0, 1, 0, 1, 1, 0, 16'hF, 4'b0000, 3'b111, 1, 16'h8);  // enable all
    v(4'b1000, 0, 1, 0, 1, 1, 3, 16'h1, 4'b0001, 3'b111, 1, 16'h8);  // force src0
    v(4'b1000, 0, 1, 0, 0, 0, 0, 16'h0, 4'b0001, 3'b011, 1, 16'h8);
    v(4'b1001, 0, 1, 0, 1, 1, 1, 16'h1, 4'b0001, 3'b011, 1, 16'h8);  // edge beats W1C
    v(4'b1000, 0, 1, 0, 1, 1, 1, 16'h1, 4'b0000, 3'b011, 1, 16'h8);
    v(4'b1000, 0, 1, 0, 0, 0, 0, 16'h0, 4'b0000, 3'b111, 1, 16'h8);

    // Reset state (src3 is falling-edge, so it idles high).
    reset = 1'b1; freeze = 1'b0; src = 4'b1000; idle_bus();
    step(); step();
    reset = 1'b0;
    check("reset_pending", 16'(pending), 16'h0);
    check("reset_ipl", 16'(bus.ipl_n), 16'h7);
    check("reset_dout", bus.reg_dout, 16'h0);
    check("reset_vpa", 16'(bus.vpa_n), 16'h1);

    foreach (vecs[i]) begin
      src = vecs[i].src;
      bus.cpu_fc = vecs[i].fc; bus.cpu_as_n = vecs[i].as_n; bus.cpu_addr = vecs[i].addr;
      bus.reg_cs = vecs[i].cs; bus.reg_we = vecs[i].we; bus.reg_addr = vecs[i].ra;
      bus.reg_din = vecs[i].din;
      step();
      check($sformatf("v%0d_pending", i), 16'(pending), 16'(vecs[i].e_pend));
      check($sformatf("v%0d_ipl", i), 16'(bus.ipl_n), 16'(vecs[i].e_ipl));
      check($sformatf("v%0d_vpa", i), 16'(bus.vpa_n), 16'(vecs[i].e_vpa));
      check($sformatf("v%0d_dout", i), bus.reg_dout, vecs[i].e_dout);
    end
    idle_bus();

    // Freeze: edges on src3 (fall) and src2 (rise) are held off; a pulse inside freeze is lost.
    freeze = 1'b1; src = 4'b0100;
    step();
    check("frz_hold0", 16'(pending), 16'h0);
    src = 4'b0101; step();
    src = 4'b0100; step();
    check("frz_hold1", 16'(pending), 16'h0);
    freeze = 1'b0;
    step();
    check("frz_release_pending", 16'(pending), 16'hC);
    step();
    check("frz_release_ipl", 16'(bus.ipl_n), 16'h0);
    src = 4'b1000; bus.reg_cs = 1'b1; bus.reg_we = 1'b1; bus.reg_addr = 2'd1;
    bus.reg_din = 16'hF;
    step();
    idle_bus();
    check("frz_cleanup_pending", 16'(pending), 16'h0);
    step();
    check("frz_cleanup_ipl", 16'(bus.ipl_n), 16'h7);

    // Reset during a held IACK: no clear until as_n rises and falls again.
    bus.cpu_fc = 3'd7; bus.cpu_as_n = 1'b0; bus.cpu_addr = 3'd4;
    reset = 1'b1;
    step();
    check("rst_iack_vpa", 16'(bus.vpa_n), 16'h0);
    check("rst_iack_pending", 16'(pending), 16'h0);
    reset = 1'b0; src = 4'b1001;
    step();
    check("rst_iack_set", 16'(pending), 16'h1);
    src = 4'b1000;
    step();
    check("rst_iack_noclr0", 16'(pending), 16'h1);
    step();
    check("rst_iack_noclr1", 16'(pending), 16'h1);
    bus.cpu_as_n = 1'b1;
    step();
    check("rst_iack_asn_high", 16'(pending), 16'h1);
    bus.cpu_as_n = 1'b0;
    step();
    check("rst_iack_rearmed", 16'(pending), 16'h0);
    idle_bus();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
